cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//  Two-master Wishbone arbiter that shares the single slave port of the unified cache between the CPU
//  instruction-fetch master (port i) and the data master (port d). Grants one whole cycle (cyc held) to
//  one master, muxes its request onto the cache port and routes ack/data back. A watchdog aborts a stuck
//  cycle with an error strobe. Sits between the CPU core and the cache.
// PARAMETERS
//  AW       25   address width (word address, matches cache)
//  DW       32   data width
//  TIMEOUT  255  cycles a granted cycle may wait for cache ack before abort (1..255, 8-bit counter)
// PORTS
//  clk_i        in   1    system clock
//  rst_ni       in   1    asynchronous active-low reset
//  i_cyc_i,i_stb_i,i_we_i in 1 / i_adr_i in AW / i_sel_i in 4 / i_dat_i in DW   instruction master request
//  i_dat_o out DW / i_ack_o out 1 / i_err_o out 1                             instruction master response
//  d_cyc_i,d_stb_i,d_we_i in 1 / d_adr_i in AW / d_sel_i in 4 / d_dat_i in DW   data master request
//  d_dat_o out DW / d_ack_o out 1 / d_err_o out 1                             data master response
//  c_cyc_o,c_stb_o,c_we_o out 1 / c_adr_o out AW / c_sel_o out 4 / c_dat_o out DW  to cache slave port
//  c_dat_i      in   DW   cache read data
//  c_ack_i      in   1    cache ack (single-cycle pulse)
//  grant_o      out  2    {grant_d, grant_i}, one-hot or 00
// BEHAVIOUR
//  - Clock/reset: one clock clk_i; rst_ni asynchronous, active-low; all flops clear on rst_ni=0.
//  - States: IDLE, GNT_I, GNT_D, ABORT. Reset -> IDLE, grant_o=00, watchdog=0, last_grant=d.
//  - IDLE: request = cyc&stb. Only one requesting -> grant it next cycle. Both -> arbitration rule
//    (see CONFIGURATION). No request -> stay.
//  - GNT_x: c_* = master x request bits, registered grant, combinational mux (0 added latency after
//    grant). Other master's ack/err held 0; its dat_o = 0. x_ack_o = c_ack_i, x_dat_o = c_dat_i.
//  - Grant held while x_cyc_i=1 (multi-beat cycles stay atomic). x_cyc_i falls -> IDLE next cycle;
//    no back-to-back grant without passing IDLE (1 dead cycle between owners).
//  - In IDLE and ABORT all c_* outputs = 0; c_ack_i outside a grant is ignored.
//  - Watchdog: 8-bit counter, clears on entering GNT_x and on every c_ack_i; increments each cycle
//    c_stb_o=1 without ack. Reaching TIMEOUT -> ABORT: x_err_o=1 for exactly one cycle, c_cyc_o=0,
//    then IDLE once x_cyc_i=0 (wait in ABORT while x_cyc_i=1).
//  - c_ack_i on the same cycle the counter reaches TIMEOUT: ack wins, no error.
//  - Master drops cyc mid-transfer: grant released next cycle; a late c_ack_i is dropped.
//  - Reset asserted mid-cycle: outputs go to reset values immediately; no ack/err delivered.
//  - last_grant register updated on each grant, used only by round-robin mode.
// CONFIGURATION
//  CACHE_ARB_ROUNDROBIN_EN defined: simultaneous requests in IDLE go to the master NOT in last_grant
//    (alternation i,d,i,d under continuous contention).
//  Not defined: fixed priority, data master always wins simultaneous requests; last_grant unused.
// TESTING
//  1. Reset, d read adr 0x0000100, cache acks after 3 cycles with 0xDEADBEEF -> grant_o=10,
//     d_ack_o 1 cycle, d_dat_o=0xDEADBEEF, i_ack_o=0 throughout.
//  2. i and d request same cycle, fixed priority -> d granted first; i granted 1 cycle after d_cyc_i
//     drops. With CACHE_ARB_ROUNDROBIN_EN and last_grant=d -> i first.
//  3. Continuous contention 8 cycles each, RR mode -> grant order i,d,i,d; fixed mode -> i starves.
//  4. d write, cache never acks, TIMEOUT=16 -> d_err_o pulse at 16th stb cycle, c_cyc_o=0 next, IDLE
//     after d_cyc_i=0.
//  5. Ack arrives on cycle counter hits TIMEOUT -> d_ack_o=1, d_err_o=0.
//  6. rst_ni low during granted cycle -> grant_o=00, all c_*=0 same cycle, no ack after release.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the unified cache's single Wishbone slave port between the CPU
// instruction-fetch master (i) and the data master (d).
//
// A master that wins arbitration owns the cache port for its whole bus cycle, which lasts
// for as long as it holds cyc. Its request is muxed onto the c_* port combinationally, and
// ack/data are routed back only to the owner. One idle cycle always separates two owners.
// A watchdog aborts a granted cycle that waits too long for an ack. The abort raises a
// one-cycle error strobe to the owner, and the arbiter then waits for that master to drop cyc.
//
// Build option:
//   CACHE_ARB_ROUNDROBIN_EN  when defined, simultaneous requests alternate between the two
//                            masters. When undefined, the data master always wins.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   i_{cyc,stb,we,adr,sel,dat}_i       instruction master request
//   i_{dat,ack,err}_o                  instruction master response
//   d_{cyc,stb,we,adr,sel,dat}_i       data master request
//   d_{dat,ack,err}_o                  data master response
//   c_{cyc,stb,we,adr,sel,dat}_o       request to cache slave port
//   c_dat_i, c_ack_i                   cache response (ack is a single-cycle pulse)
//   grant_o                            {grant_d, grant_i}; one-hot while granted, else 00
module cache_arbiter #(
  parameter int unsigned AW      = 25,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_cyc_i,
  input  logic          i_stb_i,
  input  logic          i_we_i,
  input  logic [AW-1:0] i_adr_i,
  input  logic [3:0]    i_sel_i,
  input  logic [DW-1:0] i_dat_i,
  output logic [DW-1:0] i_dat_o,
  output logic          i_ack_o,
  output logic          i_err_o,
  input  logic          d_cyc_i,
  input  logic          d_stb_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_adr_i,
  input  logic [3:0]    d_sel_i,
  input  logic [DW-1:0] d_dat_i,
  output logic [DW-1:0] d_dat_o,
  output logic          d_ack_o,
  output logic          d_err_o,
  output logic          c_cyc_o,
  output logic          c_stb_o,
  output logic          c_we_o,
  output logic [AW-1:0] c_adr_o,
  output logic [3:0]    c_sel_o,
  output logic [DW-1:0] c_dat_o,
  input  logic [DW-1:0] c_dat_i,
  input  logic          c_ack_i,
  output logic [1:0]    grant_o
);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD, StAbort} state_e;

  // The watchdog fires on the cycle the count would step onto TIMEOUT.
  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] wd_q;
  logic       abort_d_q;  // owner of the aborted cycle: 1 = d, 0 = i

  logic req_i, req_d, pick_d;
  logic gnt_i, gnt_d;
  logic abort_cyc;
  logic timeout;

  assign req_i = i_cyc_i & i_stb_i;
  assign req_d = d_cyc_i & d_stb_i;

`ifdef CACHE_ARB_ROUNDROBIN_EN
  logic last_d_q;  // 1 = last grant went to d

  // On contention, serve whichever master was not granted last.
  assign pick_d = req_d & (~req_i | ~last_d_q);
`else
  assign pick_d = req_d;
`endif

  assign gnt_i   = (state_q == StGntI);
  assign gnt_d   = (state_q == StGntD);
  assign grant_o = {gnt_d, gnt_i};

  assign abort_cyc = abort_d_q ? d_cyc_i : i_cyc_i;

  // Zero-latency request mux; everything is zero outside a grant.
  always_comb begin
    c_cyc_o = 1'b0;
    c_stb_o = 1'b0;
    c_we_o  = 1'b0;
    c_adr_o = '0;
    c_sel_o = '0;
    c_dat_o = '0;
    if (gnt_i) begin
      c_cyc_o = i_cyc_i;
      c_stb_o = i_stb_i;
      c_we_o  = i_we_i;
      c_adr_o = i_adr_i;
      c_sel_o = i_sel_i;
      c_dat_o = i_dat_i;
    end else if (gnt_d) begin
      c_cyc_o = d_cyc_i;
      c_stb_o = d_stb_i;
      c_we_o  = d_we_i;
      c_adr_o = d_adr_i;
      c_sel_o = d_sel_i;
      c_dat_o = d_dat_i;
    end
  end

  // An ack on the limit cycle wins over the abort.
  assign timeout = c_cyc_o & c_stb_o & ~c_ack_i & (wd_q == WdLast);

  assign i_ack_o = gnt_i & c_ack_i;
  assign i_err_o = gnt_i & timeout;
  assign i_dat_o = gnt_i ? c_dat_i : '0;
  assign d_ack_o = gnt_d & c_ack_i;
  assign d_err_o = gnt_d & timeout;
  assign d_dat_o = gnt_d ? c_dat_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wd_q      <= '0;
      abort_d_q <= 1'b0;
`ifdef CACHE_ARB_ROUNDROBIN_EN
      last_d_q  <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_d) begin
            state_q  <= StGntD;
            wd_q     <= '0;
`ifdef CACHE_ARB_ROUNDROBIN_EN
            last_d_q <= 1'b1;
`endif
          end else if (req_i) begin
            state_q  <= StGntI;
            wd_q     <= '0;
`ifdef CACHE_ARB_ROUNDROBIN_EN
            last_d_q <= 1'b0;
`endif
          end
        end
        StGntI, StGntD: begin
          // The owner dropping cyc ends the grant; a late ack then lands in IDLE and is lost.
          if (!c_cyc_o) begin
            state_q <= StIdle;
            wd_q    <= '0;
          end else if (timeout) begin
            state_q   <= StAbort;
            abort_d_q <= gnt_d;
            wd_q      <= '0;
          end else if (c_ack_i) begin
            wd_q <= '0;
          end else if (c_stb_o) begin
            wd_q <= wd_q + 8'd1;
          end
        end
        StAbort: begin
          if (!abort_cyc) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  localparam int unsigned AW      = 25;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned OW      = 2 + 2 * (2 + DW) + 3 + AW + 4 + DW;

`ifdef CACHE_ARB_ROUNDROBIN_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [DW-1:0] dat;
  } req_t;

  logic          clk_i;
  logic          rst_n;
  req_t          ireq, dreq;
  logic          cack;
  logic [DW-1:0] cdat;

  logic [DW-1:0] i_dat_o, d_dat_o, c_dat_o;
  logic          i_ack_o, i_err_o, d_ack_o, d_err_o;
  logic          c_cyc_o, c_stb_o, c_we_o;
  logic [AW-1:0] c_adr_o;
  logic [3:0]    c_sel_o;
  logic [1:0]    grant_o;

  cache_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_n),
    .i_cyc_i (ireq.cyc),
    .i_stb_i (ireq.stb),
    .i_we_i  (ireq.we),
    .i_adr_i (ireq.adr),
    .i_sel_i (ireq.sel),
    .i_dat_i (ireq.dat),
    .i_dat_o (i_dat_o),
    .i_ack_o (i_ack_o),
    .i_err_o (i_err_o),
    .d_cyc_i (dreq.cyc),
    .d_stb_i (dreq.stb),
    .d_we_i  (dreq.we),
    .d_adr_i (dreq.adr),
    .d_sel_i (dreq.sel),
    .d_dat_i (dreq.dat),
    .d_dat_o (d_dat_o),
    .d_ack_o (d_ack_o),
    .d_err_o (d_err_o),
    .c_cyc_o (c_cyc_o),
    .c_stb_o (c_stb_o),
    .c_we_o  (c_we_o),
    .c_adr_o (c_adr_o),
    .c_sel_o (c_sel_o),
    .c_dat_o (c_dat_o),
    .c_dat_i (cdat),
    .c_ack_i (cack),
    .grant_o (grant_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [OW-1:0] exp_q[$];
  logic [1:0]    gnt_hist[$];
  logic [1:0]    last_g   = 2'b00;
  logic [DW-1:0] d_dat_seen = '0;
  int            d_err_cnt = 0;
  int            d_ack_cnt = 0;
  int            i_ack_cnt = 0;

  // Reference model: who owns the port, whether that ownership is being aborted,
  // how long the owner has been waiting for an ack, and who was served last.
  int m_owner  = 0;  // 0 none, 1 i, 2 d
  bit m_abort  = 1'b0;
  int m_wait   = 0;
  bit m_last_d = 1'b1;

  function automatic logic [OW-1:0] pack(
    input logic [1:0] g, input logic ia, input logic ie, input logic [DW-1:0] id,
    input logic da, input logic de, input logic [DW-1:0] dd,
    input logic cc, input logic cs, input logic cw, input logic [AW-1:0] ca,
    input logic [3:0] csl, input logic [DW-1:0] cd);
    return {g, ia, ie, id, da, de, dd, cc, cs, cw, ca, csl, cd};
  endfunction

  function automatic req_t rq(input logic cyc, input logic we, input logic [AW-1:0] adr,
                              input logic [DW-1:0] dat);
    req_t r;
    r.cyc = cyc;
    r.stb = cyc;
    r.we  = we;
    r.adr = adr;
    r.sel = 4'hf;
    r.dat = dat;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.cyc = 1'b1;
    r.stb = 1'b1;
    r.we  = 1'($urandom);
    r.adr = AW'($urandom);
    r.sel = 4'($urandom);
    r.dat = DW'($urandom);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Predict this cycle's outputs from the inputs just applied, then advance the model.
  task automatic model_eval();
    logic [OW-1:0] e;
    req_t          r;
    logic          err;
    logic          bi, bd;
    e = '0;
    if (!rst_n) begin
      m_owner  = 0;
      m_abort  = 1'b0;
      m_wait   = 0;
      m_last_d = 1'b1;
    end else if (m_owner != 0 && !m_abort) begin
      r   = (m_owner == 1) ? ireq : dreq;
      err = r.cyc && r.stb && !cack && (m_wait == int'(TIMEOUT) - 1);
      if (m_owner == 1)
        e = pack(2'b01, cack, err, cdat, 1'b0, 1'b0, '0,
                 r.cyc, r.stb, r.we, r.adr, r.sel, r.dat);
      else
        e = pack(2'b10, 1'b0, 1'b0, '0, cack, err, cdat,
                 r.cyc, r.stb, r.we, r.adr, r.sel, r.dat);
      if (!r.cyc) m_owner = 0;
      else if (err) m_abort = 1'b1;
      else if (cack) m_wait = 0;
      else if (r.stb) m_wait++;
    end else if (m_abort) begin
      r = (m_owner == 1) ? ireq : dreq;
      if (!r.cyc) begin
        m_owner = 0;
        m_abort = 1'b0;
      end
    end else begin
      bi = ireq.cyc && ireq.stb;
      bd = dreq.cyc && dreq.stb;
      if (bi && bd) m_owner = RrMode ? (m_last_d ? 1 : 2) : 2;
      else if (bd) m_owner = 2;
      else if (bi) m_owner = 1;
      if (m_owner != 0) begin
        m_wait   = 0;
        m_last_d = (m_owner == 2);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input req_t ni, input req_t nd, input logic na, input logic [DW-1:0] nd_c,
                      input logic nrst);
    @(negedge clk_i);
    ireq  = ni;
    dreq  = nd;
    cack  = na;
    cdat  = nd_c;
    rst_n = nrst;
    model_eval();
  endtask

  task automatic idle(input int n, input logic nrst);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, '0, nrst);
  endtask

  // Monitor: compares every presented output cycle against the scoreboard.
  initial begin
    logic [OW-1:0] act, e;
    forever begin
      @(negedge clk_i);
      #3;
      act = pack(grant_o, i_ack_o, i_err_o, i_dat_o, d_ack_o, d_err_o, d_dat_o,
                 c_cyc_o, c_stb_o, c_we_o, c_adr_o, c_sel_o, c_dat_o);
      if (grant_o != last_g) begin
        if (grant_o != 2'b00) gnt_hist.push_back(grant_o);
        last_g = grant_o;
      end
      if (d_ack_o) begin
        d_dat_seen = d_dat_o;
        d_ack_cnt++;
      end
      if (d_err_o) d_err_cnt++;
      if (i_ack_o) i_ack_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    req_t       ni, nd;
    int         held_i, held_d, li, ld, ap;
    int         e0, a0, ia0;
    logic [1:0] ord[4];
    logic       gi, gd, nr;

    ireq  = '0;
    dreq  = '0;
    cack  = 1'b0;
    cdat  = '0;
    rst_n = 1'b0;

    // Reset state.
    idle(3, 1'b0);

    // Single d read acked on the third granted cycle.
    ia0 = i_ack_cnt;
    d_dat_seen = '0;
    nd = rq(1'b1, 1'b0, AW'(32'h100), '0);
    step('0, nd, 1'b0, '0, 1'b1);
    step('0, nd, 1'b0, '0, 1'b1);
    step('0, nd, 1'b0, '0, 1'b1);
    step('0, nd, 1'b1, 32'hDEADBEEF, 1'b1);
    step('0, '0, 1'b0, '0, 1'b1);
    idle(2, 1'b1);
    check("t1_d_dat", d_dat_seen, 32'hDEADBEEF);
    check("t1_no_i_ack", i_ack_cnt - ia0, 0);

    // Simultaneous request after reset.
    idle(1, 1'b0);
    ni = rq(1'b1, 1'b0, AW'(32'h40), '0);
    nd = rq(1'b1, 1'b1, AW'(32'h80), 32'h1234);
    for (int k = 0; k < 4; k++) step(ni, nd, 1'b1, DW'($urandom), 1'b1);
    for (int k = 0; k < 6; k++) step(ni, '0, 1'b1, DW'($urandom), 1'b1);
    idle(2, 1'b1);

    // Continuous contention: each master keeps its grant 8 cycles, drops cyc for one cycle.
    idle(2, 1'b0);
    gnt_hist.delete();
    held_i = 0;
    held_d = 0;
    for (int k = 0; k < 60; k++) begin
      gi = (m_owner == 1) && !m_abort;
      gd = (m_owner == 2) && !m_abort;
      ni = rq(1'b1, 1'b0, AW'(k), '0);
      nd = rq(1'b1, 1'b1, AW'(k + 1000), DW'(k));
      if (gi) begin
        if (held_i == 8) begin ni = '0; held_i = 0; end
        else held_i++;
      end
      if (gd) begin
        if (held_d == 8) begin nd = '0; held_d = 0; end
        else held_d++;
      end
      step(ni, nd, 1'b1, DW'($urandom), 1'b1);
    end
    idle(3, 1'b1);
    if (RrMode) begin
      ord[0] = 2'b01; ord[1] = 2'b10; ord[2] = 2'b01; ord[3] = 2'b10;
    end else begin
      ord[0] = 2'b10; ord[1] = 2'b10; ord[2] = 2'b10; ord[3] = 2'b10;
    end
    check("t3_hist_len", (gnt_hist.size() >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4; k++)
      if (gnt_hist.size() > k) check($sformatf("t3_order_%0d", k), gnt_hist[k], ord[k]);

    // d write that never gets acked: error on the 16th strobe cycle, then abort.
    idle(1, 1'b0);
    e0 = d_err_cnt;
    nd = rq(1'b1, 1'b1, AW'(32'h200), 32'hCAFEF00D);
    for (int k = 0; k < 24; k++) step('0, nd, 1'b0, '0, 1'b1);
    idle(3, 1'b1);
    check("t4_err_pulses", d_err_cnt - e0, 1);

    // Ack exactly on the limit cycle wins.
    idle(1, 1'b0);
    e0 = d_err_cnt;
    a0 = d_ack_cnt;
    nd = rq(1'b1, 1'b0, AW'(32'h300), '0);
    for (int k = 0; k <= 16; k++) step('0, nd, (k == 16), 32'h55AA55AA, 1'b1);
    idle(3, 1'b1);
    check("t5_no_err", d_err_cnt - e0, 0);
    check("t5_one_ack", d_ack_cnt - a0, 1);

    // Reset during a granted cycle, ack still arriving afterwards.
    idle(1, 1'b0);
    nd = rq(1'b1, 1'b0, AW'(32'h400), '0);
    step('0, nd, 1'b0, '0, 1'b1);
    step('0, nd, 1'b0, '0, 1'b1);
    step('0, nd, 1'b0, '0, 1'b1);
    step('0, nd, 1'b1, 32'h77, 1'b0);
    step('0, '0, 1'b1, 32'h78, 1'b0);
    a0 = d_ack_cnt;
    step('0, '0, 1'b1, 32'h79, 1'b1);
    step('0, '0, 1'b1, 32'h7A, 1'b1);
    idle(2, 1'b1);
    check("t6_no_late_ack", d_ack_cnt - a0, 0);

    // Random traffic with varying cache responsiveness and occasional resets.
    li = 0;
    ld = 0;
    ni = '0;
    nd = '0;
    for (int n = 0; n < 3000; n++) begin
      case ((n / 500) % 3)
        0:       ap = 50;
        1:       ap = 10;
        default: ap = 0;
      endcase
      if (li == 0) begin
        if ($urandom_range(0, 3) == 0) begin ni = rnd_req(); li = $urandom_range(1, 24); end
        else ni = '0;
      end else begin
        li--;
        if (li == 0) ni = '0;
        else begin
          ni.stb = ($urandom_range(0, 7) != 0);
          if ($urandom_range(0, 1) == 0) ni.adr = AW'($urandom);
        end
      end
      if (ld == 0) begin
        if ($urandom_range(0, 3) == 0) begin nd = rnd_req(); ld = $urandom_range(1, 24); end
        else nd = '0;
      end else begin
        ld--;
        if (ld == 0) nd = '0;
        else begin
          nd.stb = ($urandom_range(0, 7) != 0);
          if ($urandom_range(0, 1) == 0) nd.dat = DW'($urandom);
        end
      end
      nr = ($urandom_range(0, 399) != 0);
      step(ni, nd, ($urandom_range(0, 99) < ap), DW'($urandom), nr);
    end
    idle(3, 1'b1);

    @(negedge clk_i);
    #5;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
